loader_wr_queue: RTL and testbench
==================================

# loader_wr_queue

Write queue between the ROM loader and the SDRAM controller. It accepts single-cycle byte-write pulses (address + data) from the iNES loader at any rate. It buffers them in a small FIFO and replays them one per SDRAM write slot, where a slot is the NES clock-enable phase. This replaces the single-entry "write triggered" latch, which silently loses a byte when two loader writes land inside one slot period.

## Interface
Parameters:
- DEPTH_LOG2, default 3: FIFO depth is 2^DEPTH_LOG2 entries; legal range 1..6.
- ADDR_W, default 22: width of the byte address.

Ports:
- clk  in  1  system clock (NES core clock domain).
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; empties the queue and clears status.
- in_wr  in  1  one-cycle write strobe from the loader.
- in_addr  in  ADDR_W  write address; sampled when in_wr=1.
- in_data  in  8  write data; sampled when in_wr=1.
- slot  in  1  one-cycle pulse marking an SDRAM write slot (nes_ce==3).
- out_we  out  1  write enable to SDRAM, held for one full slot period.
- out_addr  out  ADDR_W  address presented with out_we.
- out_data  out  8  data presented with out_we.
- level  out  DEPTH_LOG2+1  current number of queued entries.
- empty  out  1  level==0, combinational from level.
- overflow  out  1  sticky; set when a push is dropped.

## Operation
- Storage: circular buffer with write pointer wp, read pointer rp, and count level. Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Push: in_wr=1 and (level<DEPTH or pop this cycle) → entry stored at wp, wp+1.
- Full drop: in_wr=1, level==DEPTH and no pop → entry discarded, overflow<=1. Queue contents are unchanged.
- Pop: occurs on every slot=1 cycle with level>0. Head goes to out_addr/out_data, out_we<=1, rp+1.
- Empty slot: slot=1 with level==0 → out_we<=0. out_addr/out_data keep their previous values.
- Hold: between slots, out_we/out_addr/out_data do not change.
- No bypass: a push and a slot in the same cycle on an empty queue do not pop that entry. It pops at the next slot.
- Simultaneous push+pop: level unchanged, including at full. A push into a full queue is accepted when a pop happens the same cycle.
- clear=1: wp=rp=level=0, out_we<=0, overflow<=0. clear has priority over push/pop in the same cycle.
- overflow clears only via reset_n or clear.

## Timing
- Reset (reset_n=0, asynchronous): out_we=0, out_addr=0, out_data=0, level=0, empty=1, overflow=0, pointers=0.
- Latency: an entry pushed in cycle t appears on outputs in cycle s+1, where s is the first slot cycle with s>t and the entry at head.
- out_we changes only in the cycle after a slot pulse (or after clear/reset). It is stable for the entire slot period.
- Throughput: at most one pop per slot. Sustained input must average ≤1 write per slot period.
- level and overflow are registered and update in the cycle after the triggering edge.
- Reset asserted mid-operation discards all queued entries. The first write after release is a fresh push.

## Configuration
- LOADER_WR_QUEUE_CHECKSUM_EN defined: adds output checksum [15:0]. It is a 16-bit wrapping sum of in_data for every accepted push; dropped pushes are excluded. Reset value 0; zeroed by clear; registered, updating in the cycle after the push.
- Undefined: no checksum port and no adder logic.

## Test plan
- Single write: push addr=0x000010, data=0xA5; slot 3 cycles later → out_we=1, out_addr=0x000010, out_data=0xA5 for 4 cycles; next empty slot → out_we=0.
- Burst: 8 pushes on consecutive cycles (DEPTH_LOG2=3), data 0x01..0x08, slot every 4 cycles → 8 consecutive out_we periods with data 0x01..0x08 in order, overflow=0, level peaks at 7.
- Overflow: 10 back-to-back pushes, no slots → level=8, overflow=1; slots drain exactly first 8 entries; overflow stays 1 until clear.
- Full push+pop: level=8, in_wr and slot same cycle → level stays 8, new entry emitted 8 slots later, overflow=0.
- Async reset mid-drain: reset_n low for 1 cycle with level=5, out_we=1 → out_we=0, level=0 immediately; following slots give out_we=0.
- With LOADER_WR_QUEUE_CHECKSUM_EN: push 0xFF, 0xFF, 0x03 → checksum=0x0201; clear → 0x0000.

Source files
------------

// File: rtl/loader_wr_queue.sv
// loader_wr_queue
//   Write queue between the iNES ROM loader and the SDRAM controller. Loader
//   byte writes arrive as single-cycle strobes at any rate. They are buffered
//   in a circular FIFO and replayed one entry per SDRAM write slot. The
//   outputs are held stable for the whole slot period.
//
//   Optional feature macro: LOADER_WR_QUEUE_CHECKSUM_EN. When it is defined,
//   a 16-bit running sum of the accepted in_data bytes is exported on
//   'checksum'.
//
// Ports
//   clk       system clock (NES core domain)
//   reset_n   asynchronous active-low reset
//   clear     synchronous flush of queue and status; wins over push/pop
//   in_wr     loader write strobe; in_addr/in_data sampled with it
//   slot      one-cycle SDRAM write-slot pulse
//   out_we    SDRAM write enable, changes only after a slot/clear/reset
//   out_addr  SDRAM byte address
//   out_data  SDRAM byte data
//   level     number of queued entries (0..2^DEPTH_LOG2)
//   empty     level == 0
//   overflow  sticky flag, set when a push is dropped on a full queue
//   checksum  (macro only) wrapping sum of the accepted bytes
module loader_wr_queue #(
    parameter int DEPTH_LOG2 = 3,
    parameter int ADDR_W     = 22
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  in_wr,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [7:0]            in_data,
    input  logic                  slot,
    output logic                  out_we,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [7:0]            out_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
`ifdef LOADER_WR_QUEUE_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    entry_t                  r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wp;
    logic [DEPTH_LOG2-1:0]   r_rp;
    logic [DEPTH_LOG2:0]     r_level;
    logic                    r_out_we;
    logic [ADDR_W-1:0]       r_out_addr;
    logic [7:0]              r_out_data;
    logic                    r_overflow;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // The pop decision uses the registered level, so a push arriving in the
    // same cycle as a slot on an empty queue waits for the next slot.
    assign w_pop  = slot && (r_level != '0);
    // A full queue still accepts a push when a pop frees a slot this cycle.
    // Reading r_mem[r_rp] gives the old head even when wp == rp.
    assign w_push = in_wr && ((r_level != FULL) || w_pop);
    assign w_drop = in_wr && !w_push;

    // The storage has no reset. Its contents only become visible through
    // the level count.
    always_ff @(posedge clk) begin
        if (w_push && !clear)
            r_mem[r_wp] <= '{addr: in_addr, data: in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_out_we   <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_out_we   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop) begin
                r_rp       <= r_rp + 1'b1;
                r_out_we   <= 1'b1;
                r_out_addr <= r_mem[r_rp].addr;
                r_out_data <= r_mem[r_rp].data;
            end else if (slot) begin
                // An empty slot drops the enable but keeps the last address
                // and data on the bus.
                r_out_we <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

`ifdef LOADER_WR_QUEUE_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_checksum <= '0;
        else if (clear)
            r_checksum <= '0;
        else if (w_push)
            r_checksum <= r_checksum + {8'h00, in_data};
    end

    assign checksum = r_checksum;
`endif

    assign out_we   = r_out_we;
    assign out_addr = r_out_addr;
    assign out_data = r_out_data;
    assign level    = r_level;
    assign empty    = (r_level == '0);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_loader_wr_queue.sv
module tb_loader_wr_queue;

    localparam int DL    = 3;
    localparam int DEPTH = 1 << DL;
    localparam int AW    = 22;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_wr = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [7:0]    in_data = '0;
    logic          slot = 1'b0;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_data;
    logic [DL:0]   level;
    logic          empty;
    logic          overflow;
`ifdef LOADER_WR_QUEUE_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    loader_wr_queue #(.DEPTH_LOG2(DL), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .in_wr    (in_wr),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .slot     (slot),
        .out_we   (out_we),
        .out_addr (out_addr),
        .out_data (out_data),
        .level    (level),
        .empty    (empty),
`ifdef LOADER_WR_QUEUE_CHECKSUM_EN
        .checksum (checksum),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the last
    // emitted write.
    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    ent_t          mq[$];
    ent_t          exp_out[$];
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_data = '0;
    bit            m_ovf = 1'b0;
    logic [15:0]   m_sum = '0;

    always @(posedge clk or negedge reset_n) begin : model
        ent_t e;
        bit   pop;
        if (!reset_n) begin
            mq.delete(); exp_out.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_ovf = 0; m_sum = '0;
        end else if (clear) begin
            mq.delete(); exp_out.delete();
            m_we = 0; m_ovf = 0; m_sum = '0;
        end else begin
            pop = slot && (mq.size() > 0);
            if (slot) begin
                if (pop) begin
                    e = mq.pop_front();
                    exp_out.push_back(e);
                    m_we = 1; m_addr = e.a; m_data = e.d;
                end else begin
                    m_we = 0;
                end
            end
            if (in_wr) begin
                if (mq.size() < DEPTH) begin
                    e.a = in_addr; e.d = in_data;
                    mq.push_back(e);
                    m_sum = m_sum + {8'h00, in_data};
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Monitor: compares the DUT against the model on every falling edge and
    // takes each emitted write off the scoreboard.
    always @(negedge clk) begin : monitor
        ent_t e;
        chk("level", 32'(level), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_we", 32'(out_we), 32'(m_we));
        chk("out_addr", 32'(out_addr), 32'(m_addr));
        chk("out_data", 32'(out_data), 32'(m_data));
`ifdef LOADER_WR_QUEUE_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(m_sum));
`endif
        if (exp_out.size() > 0) begin
            e = exp_out.pop_front();
            chk("sb_we", 32'(out_we), 32'd1);
            chk("sb_addr", 32'(out_addr), 32'(e.a));
            chk("sb_data", 32'(out_data), 32'(e.d));
        end
    end

    task automatic tick(bit wr, logic [AW-1:0] a, logic [7:0] d, bit s, bit clr = 1'b0);
        in_wr = wr; in_addr = a; in_data = d; slot = s; clear = clr;
        @(posedge clk); #1;
        in_wr = 0; slot = 0; clear = 0;
    endtask

    task automatic slots(int n);
        repeat (n) begin
            tick(0, '0, '0, 1);
            repeat (3) tick(0, '0, '0, 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_we", 32'(out_we), 32'd0);
        reset_n = 1'b1;
        tick(0, '0, '0, 0);

        // Single write.
        tick(1, 22'h000010, 8'hA5, 0);
        tick(0, '0, '0, 0);
        tick(0, '0, '0, 0);
        tick(0, '0, '0, 1);
        chk("single_we", 32'(out_we), 32'd1);
        chk("single_addr", 32'(out_addr), 32'h10);
        chk("single_data", 32'(out_data), 32'hA5);
        repeat (3) tick(0, '0, '0, 0);
        chk("single_hold", 32'(out_we), 32'd1);
        tick(0, '0, '0, 1);
        chk("single_empty_slot", 32'(out_we), 32'd0);
        chk("single_keep_data", 32'(out_data), 32'hA5);

        // Burst of 8 with a slot every 4 cycles.
        for (int i = 1; i <= 8; i++)
            tick(1, 22'(32'h100 + i), 8'(i), (i % 4) == 0);
        slots(9);
        chk("burst_ovf", 32'(overflow), 32'd0);

        // Overflow: 10 pushes with no slot.
        for (int i = 0; i < 10; i++)
            tick(1, 22'(32'h200 + i), 8'(8'h40 + i), 0);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        slots(9);
        chk("ovf_drained", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_last_data", 32'(out_data), 32'h47);
        tick(0, '0, '0, 0, 1);
        chk("clear_ovf", 32'(overflow), 32'd0);

        // Full queue with push and pop in the same cycle.
        for (int i = 0; i < 8; i++)
            tick(1, 22'(32'h300 + i), 8'(8'h80 + i), 0);
        tick(1, 22'h3AA, 8'hEE, 1);
        chk("full_pp_level", 32'(level), 32'd8);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        chk("full_pp_head", 32'(out_data), 32'h80);
        slots(9);
        chk("full_pp_last", 32'(out_data), 32'hEE);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 6; i++)
            tick(1, 22'(32'h400 + i), 8'(8'hC0 + i), 0);
        tick(0, '0, '0, 1);
        chk("pre_rst_level", 32'(level), 32'd5);
        chk("pre_rst_we", 32'(out_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(out_we), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        slots(2);
        chk("post_rst_we", 32'(out_we), 32'd0);

`ifdef LOADER_WR_QUEUE_CHECKSUM_EN
        tick(0, '0, '0, 0, 1);
        tick(1, 22'h1, 8'hFF, 0);
        tick(1, 22'h2, 8'hFF, 0);
        tick(1, 22'h3, 8'h03, 0);
        chk("csum_sum", 32'(checksum), 32'h0201);
        tick(0, '0, '0, 0, 1);
        chk("csum_clear", 32'(checksum), 32'h0000);
`endif

        // Random traffic with irregular slots and occasional clears.
        for (int i = 0; i < 2000; i++)
            tick($urandom_range(0, 99) < 30, 22'($urandom), 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 249) == 0);
        slots(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
